// File: rtl/dual_row_buffer_rng.sv
// Two line buffers (one written per cycle, both read per cycle) plus a free-running 16-bit LFSR brightness source.
// Latency: 1 cycle from rd_addr to rd_data0/rd_data1; brightness is combinational from the LFSR state.
// Backpressure: none; writes and reads occur every cycle. Optional WRITE_FIRST_EN selects write-first collisions.
module dual_row_buffer_rng #(
    parameter int          DATA_WIDTH = 24,
    parameter int          ADDR_WIDTH = 12,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  wr_sel,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data0,
    output logic [DATA_WIDTH-1:0] rd_data1,
    output logic [5:0]            brightness
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // RAM arrays are never reset so they map onto simple dual-port block RAM.
    logic [DATA_WIDTH-1:0] mem0_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem1_q [DEPTH];

    logic [DATA_WIDTH-1:0] rd_data0_q, rd_data0_d;
    logic [DATA_WIDTH-1:0] rd_data1_q, rd_data1_d;
    logic [15:0]           lfsr_q, lfsr_d;
    logic                  lfsr_fb;

    // Exactly one buffer is written every cycle, reset or not; wr_sel=1 picks buffer 0.
    always_ff @(posedge clk) begin
        if (wr_sel) begin
            mem0_q[wr_addr] <= wr_data;
        end else begin
            mem1_q[wr_addr] <= wr_data;
        end
    end

    // Read data selection: array read is read-first; the optional bypass forwards a colliding write.
    always_comb begin
        rd_data0_d = mem0_q[rd_addr];
        rd_data1_d = mem1_q[rd_addr];
`ifdef WRITE_FIRST_EN
        if (wr_sel && (wr_addr == rd_addr)) begin
            rd_data0_d = wr_data;
        end
        if (!wr_sel && (wr_addr == rd_addr)) begin
            rd_data1_d = wr_data;
        end
`endif
        if (!n_rst) begin
            rd_data0_d = '0;
            rd_data1_d = '0;
        end
    end

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1; reset reloads the non-zero seed.
    always_comb begin
        lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
        lfsr_d  = {lfsr_q[14:0], lfsr_fb};
        if (!n_rst) begin
            lfsr_d = LFSR_SEED;
        end
    end

    // State registers for read data and LFSR.
    always_ff @(posedge clk) begin
        rd_data0_q <= rd_data0_d;
        rd_data1_q <= rd_data1_d;
        lfsr_q     <= lfsr_d;
    end

    assign rd_data0   = rd_data0_q;
    assign rd_data1   = rd_data1_q;
    assign brightness = lfsr_q[5:0];

endmodule

// File: tb/tb_dual_row_buffer_rng.sv
// Bench for dual_row_buffer_rng: scoreboard of expected read data, LFSR reset/sequence/period checks.
// Latency: expected read data is due one cycle after the read address is driven.
// Backpressure: not applicable; stimulus is driven every cycle.
module tb_dual_row_buffer_rng;

    localparam int DW = 24;
    localparam int AW = 12;
    localparam logic [AW-1:0] IDLE_ADDR = 12'd3000;

    logic          clk = 1'b0;
    logic          n_rst;
    logic          wr_sel;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data0;
    logic [DW-1:0] rd_data1;
    logic [5:0]    brightness;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        int          due;
        bit          port;
        logic [23:0] exp;
        string       tag;
    } exp_t;

    exp_t sb[$];

    dual_row_buffer_rng dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .wr_sel     (wr_sel),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_addr    (rd_addr),
        .rd_data0   (rd_data0),
        .rd_data1   (rd_data1),
        .brightness (brightness)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_rd(input string tag, input bit port, input logic [23:0] e);
        exp_t item;
        item.due  = cyc + 1;
        item.port = port;
        item.exp  = e;
        item.tag  = tag;
        sb.push_back(item);
    endtask

    task automatic idle();
        wr_sel  = 1'b0;
        wr_addr = IDLE_ADDR;
        wr_data = '0;
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // Scoreboard: compare every expected read whose due cycle has arrived.
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            if (e.due < cyc) begin
                chk({e.tag, "_missed"}, e.due, cyc);
            end else begin
                chk(e.tag, e.port ? rd_data1 : rd_data0, e.exp);
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] m;
        logic [15:0] s;
        bit          zero_seen;
        bit          early_seed;

        n_rst   = 1'b0;
        idle();
        rd_addr = IDLE_ADDR;

        // Reset held for two edges
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rd0", rd_data0, 0);
        chk("rst_rd1", rd_data1, 0);
        chk("rst_bright", brightness, 6'h21);
        n_rst = 1'b1;
        @(negedge clk);
        chk("lfsr_first_state", dut.lfsr_q, 16'h59C3);
        chk("lfsr_first_bright", brightness, 6'h03);

        // Buffer select
        step();
        wr_sel = 1'b1; wr_addr = 12'd5; wr_data = 24'hFF0000;
        step();
        wr_sel = 1'b0; wr_addr = 12'd5; wr_data = 24'h00FF00;
        step();
        idle();
        rd_addr = 12'd5;
        expect_rd("bufsel_rd0", 1'b0, 24'hFF0000);
        expect_rd("bufsel_rd1", 1'b1, 24'h00FF00);

        // Line sweep into buffer 0, then look-ahead reads
        for (int a = 0; a <= 2200; a++) begin
            step();
            wr_sel = 1'b1; wr_addr = AW'(a); wr_data = DW'(a);
        end
        for (int h = 0; h <= 2198; h++) begin
            step();
            idle();
            rd_addr = AW'(h + 2);
            expect_rd("sweep_rd0", 1'b0, DW'(h + 2));
        end

        // Same-address collision in buffer 0
        step();
        wr_sel = 1'b1; wr_addr = 12'd10; wr_data = 24'h123456; rd_addr = IDLE_ADDR;
        step();
        wr_sel = 1'b1; wr_addr = 12'd10; wr_data = 24'hABCDEF; rd_addr = 12'd10;
`ifdef WRITE_FIRST_EN
        expect_rd("collide_rd0", 1'b0, 24'hABCDEF);
`else
        expect_rd("collide_rd0", 1'b0, 24'h123456);
`endif
        step();
        idle();
        rd_addr = 12'd10;
        expect_rd("collide_after_rd0", 1'b0, 24'hABCDEF);

        // Address wrap on buffer 1
        step();
        wr_sel = 1'b0; wr_addr = 12'd4095; wr_data = 24'h000001;
        step();
        wr_sel = 1'b0; wr_addr = 12'd0; wr_data = 24'h000002;
        step();
        idle();
        rd_addr = 12'd4095;
        expect_rd("wrap_hi_rd1", 1'b1, 24'h000001);
        step();
        rd_addr = 12'd0;
        expect_rd("wrap_lo_rd1", 1'b1, 24'h000002);
        expect_rd("wrap_lo_rd0", 1'b0, 24'h000000);

        // Mid-line reset clears read registers but keeps RAM contents
        step();
        n_rst = 1'b0;
        rd_addr = 12'd5;
        expect_rd("midrst_rd0", 1'b0, 24'h000000);
        expect_rd("midrst_rd1", 1'b1, 24'h000000);
        step();
        n_rst = 1'b1;
        rd_addr = 12'd5;
        expect_rd("keep_rd0", 1'b0, 24'h000005);
        expect_rd("keep_rd1", 1'b1, 24'h00FF00);
        repeat (2) @(negedge clk);

        // LFSR full period from a fresh reset
        step();
        n_rst = 1'b0;
        step();
        n_rst = 1'b1;
        chk("period_seed", dut.lfsr_q, 16'hACE1);
        m          = 16'hACE1;
        zero_seen  = 1'b0;
        early_seed = 1'b0;
        for (int i = 1; i <= 65535; i++) begin
            step();
            m = lfsr_next(m);
            chk("period_bright", brightness, m[5:0]);
            s = dut.lfsr_q;
            if (s == 16'h0000) zero_seen = 1'b1;
            if (s == 16'hACE1 && i < 65535) early_seed = 1'b1;
        end
        chk("period_end_state", dut.lfsr_q, 16'hACE1);
        chk("period_zero_seen", zero_seen, 0);
        chk("period_early_seed", early_seed, 0);

        repeat (2) @(negedge clk);
        chk("sb_drain", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
